// File: rtl/btn_pkg.sv
// Shared types and default timing constants for the push-button conditioner.
// The defaults assume a 65 MHz system clock: a 10 ms debounce and a 100 ms auto-repeat period.
package btn_pkg;

  typedef enum logic [1:0] {
    MODE_LEVEL  = 2'b00,
    MODE_PRESS  = 2'b01,
    MODE_TOGGLE = 2'b10,
    MODE_REPEAT = 2'b11
  } btn_mode_t;

  localparam int DB_CYCLES_DEF     = 650_000;
  localparam int REPEAT_CYCLES_DEF = 6_500_000;

endpackage

// File: rtl/btn_channel.sv
// One button channel: two-flop synchroniser, debounce counter, edge pulses,
// toggle bit and auto-repeat timer, with a registered mode-selected output.
module btn_channel
  import btn_pkg::*;
#(
  parameter int DB_CYCLES     = DB_CYCLES_DEF,
  parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_in,
  input  logic [1:0] mode,
  output logic       btn_level,
  output logic       btn_press,
  output logic       btn_release,
  output logic       btn_out
);

  localparam int DBW = $clog2(DB_CYCLES);
  localparam int RPW = $clog2(REPEAT_CYCLES);
  localparam logic [DBW-1:0] DB_MAX = DBW'(DB_CYCLES - 1);
  localparam logic [RPW-1:0] RP_MAX = RPW'(REPEAT_CYCLES - 1);

  logic [1:0]     sync_q;
  logic [DBW-1:0] db_cnt, db_cnt_nxt;
  logic [RPW-1:0] rep_cnt, rep_cnt_nxt;
  logic           toggle_q, toggle_nxt;
  logic           lvl_nxt, press_nxt, rel_nxt, rep_nxt, out_nxt;

  always_comb begin
    lvl_nxt     = btn_level;
    db_cnt_nxt  = '0;
    rep_cnt_nxt = '0;
    rep_nxt     = 1'b0;
    out_nxt     = 1'b0;

    if (sync_q[1] != btn_level) begin
      if (db_cnt == DB_MAX) begin
        lvl_nxt = ~btn_level;
      end else begin
        db_cnt_nxt = db_cnt + 1'b1;
      end
    end

    press_nxt  = lvl_nxt & ~btn_level;
    rel_nxt    = ~lvl_nxt & btn_level;
    toggle_nxt = toggle_q ^ press_nxt;

    // Gating on the next level stops repeats in the very cycle the level drops.
    if (lvl_nxt && !press_nxt) begin
      if (rep_cnt == RP_MAX) begin
        rep_nxt = 1'b1;
      end else begin
        rep_cnt_nxt = rep_cnt + 1'b1;
      end
    end

    case (btn_mode_t'(mode))
      MODE_LEVEL:  out_nxt = lvl_nxt;
      MODE_PRESS:  out_nxt = press_nxt;
      MODE_TOGGLE: out_nxt = toggle_nxt;
      MODE_REPEAT: out_nxt = press_nxt | rep_nxt;
      default:     out_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q      <= '0;
      db_cnt      <= '0;
      rep_cnt     <= '0;
      toggle_q    <= 1'b0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      btn_out     <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], btn_in};
      db_cnt      <= db_cnt_nxt;
      rep_cnt     <= rep_cnt_nxt;
      toggle_q    <= toggle_nxt;
      btn_level   <= lvl_nxt;
      btn_press   <= press_nxt;
      btn_release <= rel_nxt;
      btn_out     <= out_nxt;
    end
  end

endmodule

// File: rtl/btn_conditioner.sv
// Multi-channel button conditioner: N_CH independent btn_channel instances
// sharing clock and reset, with per-channel 2-bit mode fields.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int N_CH          = 5,
  parameter int DB_CYCLES     = DB_CYCLES_DEF,
  parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   btn_in,
  input  logic [2*N_CH-1:0] mode,
  output logic [N_CH-1:0]   btn_level,
  output logic [N_CH-1:0]   btn_press,
  output logic [N_CH-1:0]   btn_release,
  output logic [N_CH-1:0]   btn_out
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    btn_channel #(
      .DB_CYCLES    (DB_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .btn_in     (btn_in[i]),
      .mode       (mode[2*i+1:2*i]),
      .btn_level  (btn_level[i]),
      .btn_press  (btn_press[i]),
      .btn_release(btn_release[i]),
      .btn_out    (btn_out[i])
    );
  end

endmodule

// File: doc/btn_conditioner.md
# btn_conditioner

Parametrised multi-channel push-button conditioner: synchronises, debounces and edge-detects N raw Basys3 button/switch inputs and produces a registered, mode-selectable control output per channel. It sits between the board pins and the game control logic (ship movement, fire, pause). It replaces ad-hoc single-bit toggle registers with one block offering level, press-pulse, toggle and auto-repeat behaviour per channel.

## Interface
- N_CH, 5, number of independent button channels (1..16)
- DB_CYCLES, 650_000, cycles the synchronised input must stay stable before the debounced level changes (≥2)
- REPEAT_CYCLES, 6_500_000, auto-repeat period in cycles while held (≥2)
- clk  in  1  posedge-active system clock
- rst  in  1  synchronous, active-high reset
- btn_in  in  N_CH  raw asynchronous button levels, 1 = pressed
- mode  in  2*N_CH  per-channel mode; channel i uses mode[2i+1:2i]
- btn_level  out  N_CH  debounced level
- btn_press  out  N_CH  one-cycle pulse on debounced 0→1
- btn_release  out  N_CH  one-cycle pulse on debounced 1→0
- btn_out  out  N_CH  mode-selected output

## Operation
- Per channel, all state is independent; no cross-channel interaction.
- Synchroniser: two flip-flops, reset to 0.
- Debounce: counter (width $clog2(DB_CYCLES)) increments each cycle that sync output ≠ btn_level; cleared to 0 on any cycle they are equal. When the counter is DB_CYCLES-1 and a mismatch persists, btn_level flips and the counter clears. Glitches shorter than DB_CYCLES never reach btn_level.
- btn_press / btn_release: high exactly in the first cycle btn_level holds its new value.
- Toggle bit: inverts on every btn_press, regardless of mode; retained across mode changes.
- Repeat counter (width $clog2(REPEAT_CYCLES)): cleared on btn_press and while btn_level = 0; while held it counts to REPEAT_CYCLES-1, then wraps to 0 and issues a repeat pulse.
- Modes: 00 LEVEL → btn_out = btn_level; 01 PRESS → btn_out = btn_press; 10 TOGGLE → btn_out = toggle bit; 11 REPEAT → btn_out = btn_press OR repeat pulse.
- Mode changes take effect at the next clock edge; they do not reset counters or the toggle bit.

## Timing
- All outputs are registered; reset value of every output and internal register is 0.
- Clean step on btn_in sampled at edge k: btn_level, btn_press/btn_release and btn_out change after edge k+DB_CYCLES+1 (latency DB_CYCLES+2 edges counting edge k as first).
- REPEAT mode, held button: pulses at press cycle P, then P+REPEAT_CYCLES, P+2·REPEAT_CYCLES, …; the pulse stops in the cycle btn_level falls.
- Button held through reset: after rst deasserts, treated as a fresh press (btn_press fires after the normal latency).
- rst asserted mid-debounce or mid-repeat: all state clears at that edge; no pulse is emitted.
- Simultaneous press and repeat wrap cannot occur (press clears the repeat counter).

## Structure
- Package btn_pkg: typedef enum logic [1:0] btn_mode_t {MODE_LEVEL, MODE_PRESS, MODE_TOGGLE, MODE_REPEAT}; default DB_CYCLES / REPEAT_CYCLES constants for a 65 MHz clock.
- Sub-module btn_channel (one channel: sync, debounce, edge, toggle, repeat, output mux); the top instantiates N_CH copies in a generate loop and slices the buses.

## Test plan
Bench uses N_CH=2, DB_CYCLES=4, REPEAT_CYCLES=8.
- Reset, btn_in=0 → all outputs 0 for 20 cycles.
- Ch0 LEVEL, step 0→1 at edge k → btn_level[0] and btn_out[0] = 1 from after edge k+5; btn_press[0] high for exactly that one cycle; ch1 unaffected.
- Ch0 glitch of 3 cycles high, then low → btn_level, btn_press, btn_out stay 0.
- Ch1 TOGGLE, three clean press/release cycles → btn_out[1] goes 1, 0, 1; two-cycle bounce before each press causes no extra toggle.
- Ch0 REPEAT, held 30 cycles after debounce → btn_out[0] pulses at P, P+8, P+16, P+24 (4 pulses), each one cycle wide; none after release.
- rst asserted 2 cycles into a debounce on ch0 → outputs stay 0; input still high after reset deasserts → press detected 6 edges later.
